multi_dataflow_tile_sched: RTL and testbench

Tile scheduler for the multi_dataflow HWPE.
- Sits between the slave register file and the engine/streamer pair.
- On a trigger, latches the job configuration and runs nb_iter tiles.
- Per tile: computes the inStream0/outStream0 base addresses, fires the source, sink and engine starts, waits for both completions, then advances the tile index.
- Raises a one-cycle done event when the job finishes.

---
 rtl/multi_dataflow_tile_sched.sv | 197 +++++++++++++++++++
 tb/tb_multi_dataflow_tile_sched.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_dataflow_tile_sched.sv
// Tile scheduler for the multi_dataflow HWPE: walks nb_iter tiles in a 2-D raster,
// handshaking source/sink/engine per tile. Optional abort path: MULTI_DATAFLOW_SCHED_ABORT_EN.
module multi_dataflow_tile_sched #(
  parameter int NB_ITER_W = 16,
  parameter int ADDR_W    = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [NB_ITER_W-1:0] nb_iter_i,
  input  logic [NB_ITER_W-1:0] tiles_per_line_i,
  input  logic [ADDR_W-1:0]    in0_base_i,
  input  logic [ADDR_W-1:0]    out0_base_i,
  input  logic [ADDR_W-1:0]    line_stride_i,
  input  logic [ADDR_W-1:0]    tile_stride_i,
  input  logic                 in0_ready_i,
  input  logic                 out0_ready_i,
  input  logic                 out0_done_i,
  input  logic                 eng_ready_i,
  input  logic                 eng_done_i,
`ifdef MULTI_DATAFLOW_SCHED_ABORT_EN
  input  logic                 abort_i,
  output logic                 aborted_o,
`endif
  output logic                 in0_req_start_o,
  output logic                 out0_req_start_o,
  output logic                 eng_start_o,
  output logic [ADDR_W-1:0]    in0_addr_o,
  output logic [ADDR_W-1:0]    out0_addr_o,
  output logic                 eng_clear_o,
  output logic [NB_ITER_W-1:0] iter_idx_o,
  output logic                 busy_o,
  output logic                 done_o
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    COMPUTE   = 3'd2,
    WAIT      = 3'd3,
    UPDATEIDX = 3'd4,
    TERMINATE = 3'd5
  } state_t;

  state_t               state_r;
  logic [NB_ITER_W-1:0] nb_iter_r;
  logic [NB_ITER_W-1:0] col_last_r;
  logic [NB_ITER_W-1:0] iter_idx_r;
  logic [NB_ITER_W-1:0] col_r;
  logic [NB_ITER_W-1:0] row_r;
  logic [ADDR_W-1:0]    line_stride_r;
  logic [ADDR_W-1:0]    tile_stride_r;
  logic [ADDR_W-1:0]    in0_addr_r;
  logic [ADDR_W-1:0]    out0_addr_r;
  logic [ADDR_W-1:0]    in0_row_r;
  logic [ADDR_W-1:0]    out0_row_r;
  logic                 out0_flag_r;
  logic                 eng_flag_r;
  logic                 done_r;
  logic                 clear_r;
  logic                 abort_s;
  logic                 fire_s;

`ifdef MULTI_DATAFLOW_SCHED_ABORT_EN
  logic                 abort_flag_r;
  logic                 aborted_r;

  // Abort only applies while a job is active and not already terminating
  assign abort_s   = abort_i & (state_r != IDLE) & (state_r != TERMINATE);
  assign aborted_o = aborted_r;
`else
  assign abort_s   = 1'b0;
`endif

  // Start pulses are combinational so they coincide with the readies they depend on
  assign fire_s = (state_r == START) & in0_ready_i & out0_ready_i & eng_ready_i & ~abort_s;

  assign in0_req_start_o  = fire_s;
  assign out0_req_start_o = fire_s;
  assign eng_start_o      = fire_s;
  assign in0_addr_o       = in0_addr_r;
  assign out0_addr_o      = out0_addr_r;
  assign iter_idx_o       = iter_idx_r;
  assign eng_clear_o      = clear_r;
  assign done_o           = done_r;
  assign busy_o           = (state_r != IDLE);

  // Scheduler FSM with tile counters, address accumulators and sticky done flags
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r       <= IDLE;
      nb_iter_r     <= '0;
      col_last_r    <= '0;
      iter_idx_r    <= '0;
      col_r         <= '0;
      row_r         <= '0;
      line_stride_r <= '0;
      tile_stride_r <= '0;
      in0_addr_r    <= '0;
      out0_addr_r   <= '0;
      in0_row_r     <= '0;
      out0_row_r    <= '0;
      out0_flag_r   <= 1'b0;
      eng_flag_r    <= 1'b0;
      done_r        <= 1'b0;
      clear_r       <= 1'b0;
`ifdef MULTI_DATAFLOW_SCHED_ABORT_EN
      abort_flag_r  <= 1'b0;
      aborted_r     <= 1'b0;
`endif
    end else begin
      done_r  <= (state_r == TERMINATE);
      clear_r <= (state_r == TERMINATE);
`ifdef MULTI_DATAFLOW_SCHED_ABORT_EN
      aborted_r <= (state_r == TERMINATE) & abort_flag_r;
      if (abort_s) begin
        abort_flag_r <= 1'b1;
      end else if (state_r == IDLE) begin
        abort_flag_r <= 1'b0;
      end else begin
        abort_flag_r <= abort_flag_r;
      end
`endif

      // A done pulse coinciding with a fresh start belongs to the new tile
      if (fire_s) begin
        out0_flag_r <= out0_done_i;
        eng_flag_r  <= eng_done_i;
      end else begin
        out0_flag_r <= out0_flag_r | out0_done_i;
        eng_flag_r  <= eng_flag_r | eng_done_i;
      end

      if (abort_s) begin
        state_r <= TERMINATE;
      end else begin
        case (state_r)
          IDLE: begin
            if (start_i) begin
              nb_iter_r     <= nb_iter_i;
              col_last_r    <= (tiles_per_line_i == '0) ? '0 : tiles_per_line_i - NB_ITER_W'(1);
              line_stride_r <= line_stride_i;
              tile_stride_r <= tile_stride_i;
              iter_idx_r    <= '0;
              col_r         <= '0;
              row_r         <= '0;
              in0_addr_r    <= in0_base_i;
              out0_addr_r   <= out0_base_i;
              in0_row_r     <= in0_base_i;
              out0_row_r    <= out0_base_i;
              state_r       <= (nb_iter_i != '0) ? START : TERMINATE;
            end
          end
          START: begin
            if (fire_s) begin
              state_r <= COMPUTE;
            end
          end
          COMPUTE: begin
            if (eng_flag_r | eng_done_i) begin
              state_r <= WAIT;
            end
          end
          WAIT: begin
            if (out0_flag_r) begin
              state_r <= (iter_idx_r == nb_iter_r - NB_ITER_W'(1)) ? TERMINATE : UPDATEIDX;
            end
          end
          UPDATEIDX: begin
            iter_idx_r <= iter_idx_r + NB_ITER_W'(1);
            // Row bases are accumulated so the next line never needs a multiply
            if (col_r == col_last_r) begin
              col_r       <= '0;
              row_r       <= row_r + NB_ITER_W'(1);
              in0_row_r   <= in0_row_r + line_stride_r;
              out0_row_r  <= out0_row_r + line_stride_r;
              in0_addr_r  <= in0_row_r + line_stride_r;
              out0_addr_r <= out0_row_r + line_stride_r;
            end else begin
              col_r       <= col_r + NB_ITER_W'(1);
              in0_addr_r  <= in0_addr_r + tile_stride_r;
              out0_addr_r <= out0_addr_r + tile_stride_r;
            end
            state_r <= START;
          end
          TERMINATE: begin
            state_r <= IDLE;
          end
          default: begin
            state_r <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_multi_dataflow_tile_sched.sv
// Directed self-checking bench for multi_dataflow_tile_sched; abort scenario is
// exercised only when MULTI_DATAFLOW_SCHED_ABORT_EN is defined.
module tb_multi_dataflow_tile_sched;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [15:0] nb_iter_i;
  logic [15:0] tiles_per_line_i;
  logic [31:0] in0_base_i, out0_base_i, line_stride_i, tile_stride_i;
  logic        in0_ready_i, out0_ready_i, out0_done_i, eng_ready_i, eng_done_i;
  logic        in0_req_start_o, out0_req_start_o, eng_start_o, eng_clear_o, busy_o, done_o;
  logic [31:0] in0_addr_o, out0_addr_o;
  logic [15:0] iter_idx_o;
`ifdef MULTI_DATAFLOW_SCHED_ABORT_EN
  logic        abort_i;
  logic        aborted_o;
`endif

  int checks = 0;
  int errors = 0;
  int n_in0 = 0, n_out0 = 0, n_eng = 0, n_done = 0, n_clr = 0, n_abt = 0;
  int b_in0, b_out0, b_eng, b_done, b_clr, b_abt;

  multi_dataflow_tile_sched dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .start_i          (start_i),
    .nb_iter_i        (nb_iter_i),
    .tiles_per_line_i (tiles_per_line_i),
    .in0_base_i       (in0_base_i),
    .out0_base_i      (out0_base_i),
    .line_stride_i    (line_stride_i),
    .tile_stride_i    (tile_stride_i),
    .in0_ready_i      (in0_ready_i),
    .out0_ready_i     (out0_ready_i),
    .out0_done_i      (out0_done_i),
    .eng_ready_i      (eng_ready_i),
    .eng_done_i       (eng_done_i),
`ifdef MULTI_DATAFLOW_SCHED_ABORT_EN
    .abort_i          (abort_i),
    .aborted_o        (aborted_o),
`endif
    .in0_req_start_o  (in0_req_start_o),
    .out0_req_start_o (out0_req_start_o),
    .eng_start_o      (eng_start_o),
    .in0_addr_o       (in0_addr_o),
    .out0_addr_o      (out0_addr_o),
    .eng_clear_o      (eng_clear_o),
    .iter_idx_o       (iter_idx_o),
    .busy_o           (busy_o),
    .done_o           (done_o)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle
  always @(negedge clk) begin
    if (in0_req_start_o)  n_in0++;
    if (out0_req_start_o) n_out0++;
    if (eng_start_o)      n_eng++;
    if (done_o)           n_done++;
    if (eng_clear_o)      n_clr++;
`ifdef MULTI_DATAFLOW_SCHED_ABORT_EN
    if (aborted_o)        n_abt++;
`endif
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    b_in0 = n_in0; b_out0 = n_out0; b_eng = n_eng;
    b_done = n_done; b_clr = n_clr; b_abt = n_abt;
  endtask

  task automatic wait_pulse(input string tag);
    int w;
    w = 0;
    while (!in0_req_start_o && w < 30) begin
      step();
      w++;
    end
    check_eq(tag, {31'd0, in0_req_start_o}, 32'd1);
  endtask

  task automatic wait_done(input string tag);
    int w;
    w = 0;
    while (!done_o && w < 30) begin
      step();
      w++;
    end
    check_eq(tag, {31'd0, done_o}, 32'd1);
    step();
  endtask

  // From a start-pulse cycle: one cycle in COMPUTE, then both completions together
  task automatic finish_tile();
    step();
    eng_done_i = 1'b1; out0_done_i = 1'b1;
    step();
    eng_done_i = 1'b0; out0_done_i = 1'b0;
  endtask

  task automatic launch();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  logic [31:0] walk_in0 [6];

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    walk_in0[0] = 32'h0;   walk_in0[1] = 32'h10;  walk_in0[2] = 32'h20;
    walk_in0[3] = 32'h100; walk_in0[4] = 32'h110; walk_in0[5] = 32'h120;
    rst_i = 1'b1; start_i = 1'b0; nb_iter_i = 16'd0; tiles_per_line_i = 16'd0;
    in0_base_i = 32'd0; out0_base_i = 32'd0; line_stride_i = 32'd0; tile_stride_i = 32'd0;
    in0_ready_i = 1'b1; out0_ready_i = 1'b1; eng_ready_i = 1'b1;
    out0_done_i = 1'b0; eng_done_i = 1'b0;
`ifdef MULTI_DATAFLOW_SCHED_ABORT_EN
    abort_i = 1'b0;
`endif
    repeat (3) step();

    // Reset state (readies high, so any pulse would be visible)
    check_eq("rst_busy", {31'd0, busy_o}, 32'd0);
    check_eq("rst_done", {31'd0, done_o}, 32'd0);
    check_eq("rst_iter", {16'd0, iter_idx_o}, 32'd0);
    check_eq("rst_in0_addr", in0_addr_o, 32'd0);
    check_eq("rst_out0_addr", out0_addr_o, 32'd0);
    check_eq("rst_start", {31'd0, in0_req_start_o}, 32'd0);
    rst_i = 1'b0;
    step();

    // Single tile
    snap();
    nb_iter_i = 16'd1; tiles_per_line_i = 16'd1;
    in0_base_i = 32'h1000; out0_base_i = 32'h2000;
    launch();
    check_eq("t1_pulse_in0", {31'd0, in0_req_start_o}, 32'd1);
    check_eq("t1_pulse_out0", {31'd0, out0_req_start_o}, 32'd1);
    check_eq("t1_pulse_eng", {31'd0, eng_start_o}, 32'd1);
    check_eq("t1_in0_addr", in0_addr_o, 32'h1000);
    check_eq("t1_out0_addr", out0_addr_o, 32'h2000);
    repeat (4) step();
    eng_done_i = 1'b1; step(); eng_done_i = 1'b0;
    out0_done_i = 1'b1; step(); out0_done_i = 1'b0;
    check_eq("t1_wait_busy", {31'd0, busy_o}, 32'd1);
    step();
    check_eq("t1_term_nodone", {31'd0, done_o}, 32'd0);
    check_eq("t1_term_busy", {31'd0, busy_o}, 32'd1);
    step();
    check_eq("t1_done", {31'd0, done_o}, 32'd1);
    check_eq("t1_clear", {31'd0, eng_clear_o}, 32'd1);
    check_eq("t1_busy_low", {31'd0, busy_o}, 32'd0);
    step();
    check_eq("t1_done_once", {31'd0, done_o}, 32'd0);
    check_eq("t1_n_in0", n_in0 - b_in0, 32'd1);
    check_eq("t1_n_out0", n_out0 - b_out0, 32'd1);
    check_eq("t1_n_eng", n_eng - b_eng, 32'd1);
    check_eq("t1_n_done", n_done - b_done, 32'd1);
    check_eq("t1_n_clr", n_clr - b_clr, 32'd1);

    // 2-D walk: 3 tiles per line, 6 tiles
    snap();
    nb_iter_i = 16'd6; tiles_per_line_i = 16'd3;
    in0_base_i = 32'h0; out0_base_i = 32'h8000;
    tile_stride_i = 32'h10; line_stride_i = 32'h100;
    launch();
    for (int k = 0; k < 6; k++) begin
      wait_pulse($sformatf("walk_pulse%0d", k));
      check_eq($sformatf("walk_in0_%0d", k), in0_addr_o, walk_in0[k]);
      check_eq($sformatf("walk_out0_%0d", k), out0_addr_o, walk_in0[k] + 32'h8000);
      check_eq($sformatf("walk_iter_%0d", k), {16'd0, iter_idx_o}, k);
      finish_tile();
    end
    wait_done("walk_done");
    check_eq("walk_n_in0", n_in0 - b_in0, 32'd6);
    check_eq("walk_n_done", n_done - b_done, 32'd1);

    // Done ordering; tiles_per_line 0 behaves as 1, so every tile starts a new line
    snap();
    nb_iter_i = 16'd2; tiles_per_line_i = 16'd0;
    in0_base_i = 32'h3000; out0_base_i = 32'h4000;
    tile_stride_i = 32'h4; line_stride_i = 32'h40;
    launch();
    step();
    out0_done_i = 1'b1; step(); out0_done_i = 1'b0;
    repeat (2) step();
    eng_done_i = 1'b1; step(); eng_done_i = 1'b0;
    step();
    step();
    check_eq("ord_restart", {31'd0, in0_req_start_o}, 32'd1);
    check_eq("ord_in0_addr", in0_addr_o, 32'h3040);
    check_eq("ord_out0_addr", out0_addr_o, 32'h4040);
    check_eq("ord_iter", {16'd0, iter_idx_o}, 32'd1);
    finish_tile();
    step();
    check_eq("ord_term_nodone", {31'd0, done_o}, 32'd0);
    step();
    check_eq("ord_done", {31'd0, done_o}, 32'd1);
    check_eq("ord_busy_low", {31'd0, busy_o}, 32'd0);
    step();

    // Backpressure: source not ready for 10 cycles
    snap();
    nb_iter_i = 16'd1; in0_base_i = 32'h50;
    in0_ready_i = 1'b0;
    launch();
    repeat (10) step();
    check_eq("bp_no_pulse", n_in0 - b_in0, 32'd0);
    check_eq("bp_busy", {31'd0, busy_o}, 32'd1);
    check_eq("bp_addr_held", in0_addr_o, 32'h50);
    in0_ready_i = 1'b1;
    #1;
    check_eq("bp_release", {31'd0, in0_req_start_o}, 32'd1);
    finish_tile();
    wait_done("bp_done");

    // Empty job
    snap();
    nb_iter_i = 16'd0;
    launch();
    check_eq("empty_c1_nodone", {31'd0, done_o}, 32'd0);
    step();
    check_eq("empty_c2_done", {31'd0, done_o}, 32'd1);
    step();
    check_eq("empty_no_starts", n_in0 - b_in0, 32'd0);
    check_eq("empty_n_done", n_done - b_done, 32'd1);

    // Reset mid-job, with a start_i while busy that must be ignored
    nb_iter_i = 16'd4; tiles_per_line_i = 16'd4;
    in0_base_i = 32'h500; out0_base_i = 32'h600;
    tile_stride_i = 32'h20; line_stride_i = 32'h1000;
    launch();
    finish_tile();
    wait_pulse("rs_pulse1");
    step();
    in0_base_i = 32'hF000; nb_iter_i = 16'd1;
    start_i = 1'b1; step(); start_i = 1'b0;
    eng_done_i = 1'b1; out0_done_i = 1'b1; step();
    eng_done_i = 1'b0; out0_done_i = 1'b0;
    wait_pulse("rs_pulse2");
    check_eq("rs_ignored_addr", in0_addr_o, 32'h540);
    check_eq("rs_out0_addr", out0_addr_o, 32'h640);
    check_eq("rs_iter", {16'd0, iter_idx_o}, 32'd2);
    step();
    snap();
    rst_i = 1'b1; step(); rst_i = 1'b0;
    check_eq("rs_busy", {31'd0, busy_o}, 32'd0);
    check_eq("rs_iter0", {16'd0, iter_idx_o}, 32'd0);
    check_eq("rs_in0_0", in0_addr_o, 32'd0);
    check_eq("rs_out0_0", out0_addr_o, 32'd0);
    repeat (5) step();
    check_eq("rs_no_done", n_done - b_done, 32'd0);
    check_eq("rs_no_clear", n_clr - b_clr, 32'd0);

    // Retrigger after reset
    snap();
    nb_iter_i = 16'd1; in0_base_i = 32'h700; out0_base_i = 32'h780;
    launch();
    check_eq("rt_pulse", {31'd0, in0_req_start_o}, 32'd1);
    check_eq("rt_in0_addr", in0_addr_o, 32'h700);
    finish_tile();
    wait_done("rt_done");
    check_eq("rt_n_in0", n_in0 - b_in0, 32'd1);

`ifdef MULTI_DATAFLOW_SCHED_ABORT_EN
    // Abort during WAIT of the first tile of five
    snap();
    nb_iter_i = 16'd5; tiles_per_line_i = 16'd5;
    launch();
    step();
    eng_done_i = 1'b1; step(); eng_done_i = 1'b0;
    abort_i = 1'b1; step(); abort_i = 1'b0;
    check_eq("ab_term_nodone", {31'd0, done_o}, 32'd0);
    step();
    check_eq("ab_done", {31'd0, done_o}, 32'd1);
    check_eq("ab_aborted", {31'd0, aborted_o}, 32'd1);
    check_eq("ab_busy_low", {31'd0, busy_o}, 32'd0);
    out0_done_i = 1'b1; step(); out0_done_i = 1'b0;
    repeat (5) step();
    check_eq("ab_n_in0", n_in0 - b_in0, 32'd1);
    check_eq("ab_n_done", n_done - b_done, 32'd1);
    check_eq("ab_n_abt", n_abt - b_abt, 32'd1);
    abort_i = 1'b1; step(); abort_i = 1'b0;
    step();
    check_eq("ab_idle_noeffect", n_done - b_done, 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
